// File: rtl/sp_ram_initiator_pkg.sv
// rtl/sp_ram_initiator_pkg.sv - shared types and helpers for the single-port RAM initiator
package sp_ram_init_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_TAG_WIDTH  = DEF_DATA_WIDTH / 8;

    // One DIFT tag bit per data byte
    function automatic int tag_width(input int data_width);
        return data_width / 8;
    endfunction

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_TAG_WIDTH-1:0]  tag;
    } rsp_t;

    typedef enum logic [1:0] {
        OP_LOAD      = 2'd0,
        OP_STORE     = 2'd1,
        OP_TAG_STORE = 2'd2
    } op_e;

endpackage

// File: rtl/sp_ram_initiator_if.sv
// rtl/sp_ram_initiator_if.sv - core-side req/gnt/rvalid/rready load-store interface
interface sp_ram_initiator_if #(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32
);
    localparam int TAG_WIDTH = sp_ram_init_pkg::tag_width(DATA_WIDTH);

    logic                  req;
    logic                  gnt;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic                  tag_only;
    logic [TAG_WIDTH-1:0]  be;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wtag;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [TAG_WIDTH-1:0]  rtag;

    modport master (
        output req, addr, we, tag_only, be, wdata, wtag, rready,
        input  gnt, rvalid, rdata, rtag
    );

    modport slave (
        input  req, addr, we, tag_only, be, wdata, wtag, rready,
        output gnt, rvalid, rdata, rtag
    );

endinterface

// File: rtl/sp_ram_initiator_rsp_fifo.sv
// rtl/sp_ram_initiator_rsp_fifo.sv - response buffer FIFO with push/pop/count
module sp_ram_rsp_fifo
    import sp_ram_init_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = rsp_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  entry_t                       push_data,
    input  logic                         pop,
    output entry_t                       head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    // Storage is not reset: count alone says which entries are meaningful
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; push and pop may coincide
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sp_ram_initiator.sv
// rtl/sp_ram_initiator.sv - load-store to single-port RAM initiator with DIFT tags
module sp_ram_initiator
    import sp_ram_init_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int RSP_DEPTH  = 2,
    localparam int TAG_WIDTH = tag_width(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst_i,
    sp_ram_initiator_if.slave      core,
    output logic                   ram_en_o,
    output logic [ADDR_WIDTH-1:0]  ram_addr_o,
    output logic                   ram_we_o,
    output logic [TAG_WIDTH-1:0]   ram_be_o,
    output logic [DATA_WIDTH-1:0]  ram_wdata_o,
    output logic                   ram_we_tag_o,
    output logic                   ram_wdata_tag_o,
    input  logic [DATA_WIDTH-1:0]  ram_rdata_i,
    input  logic [TAG_WIDTH-1:0]   ram_rdata_tag_i
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [TAG_WIDTH-1:0]  tag;
    } entry_t;

    logic             inflight_valid;
    op_e              inflight_op;
    op_e              req_op;
    logic             gnt;
    logic [CNT_W-1:0] count;
    logic [CNT_W:0]   occ;
    logic             empty;
    logic             push;
    logic             pop;
    logic             rvalid;
    entry_t           captured;
    entry_t           head;
    entry_t           rsp_out;

    // Credits count the in-flight access too, so a response always has a slot;
    // a same-cycle pop is deliberately not credited back until it is registered
    assign occ = {1'b0, count} + (CNT_W + 1)'(inflight_valid);
    assign gnt = core.req & ~rst_i & (occ < (CNT_W + 1)'(RSP_DEPTH));
    assign core.gnt = gnt;

    // Classify the presented request
    always_comb begin
        req_op = OP_LOAD;
        if (core.we) begin
            req_op = core.tag_only ? OP_TAG_STORE : OP_STORE;
        end
    end

    // RAM port is driven straight from the core request in the grant cycle
    always_comb begin
        ram_en_o        = 1'b0;
        ram_addr_o      = '0;
        ram_we_o        = 1'b0;
        ram_be_o        = '0;
        ram_wdata_o     = '0;
        ram_we_tag_o    = 1'b0;
        ram_wdata_tag_o = 1'b0;
        if (gnt) begin
            ram_en_o   = 1'b1;
            ram_addr_o = core.addr;
            ram_be_o   = core.be;
            if (req_op != OP_LOAD) begin
                ram_we_o        = (req_op == OP_STORE);
                ram_wdata_o     = core.wdata;
                ram_we_tag_o    = 1'b1;
                ram_wdata_tag_o = core.wtag;
            end
        end
    end

    // Track the single access whose response arrives next cycle
    always_ff @(posedge clk) begin
        if (rst_i) begin
            inflight_valid <= 1'b0;
            inflight_op    <= OP_LOAD;
        end else begin
            inflight_valid <= gnt;
            inflight_op    <= req_op;
        end
    end

    // Loads return RAM data; stores complete with an all-zero response
    always_comb begin
        captured = '0;
        if (inflight_op == OP_LOAD) begin
            captured.data = ram_rdata_i;
            captured.tag  = ram_rdata_tag_i;
        end
    end

    // The fresh response bypasses the buffer only when nothing older is waiting
    assign push = ~rst_i & inflight_valid & (~empty | ~core.rready);
    assign pop  = ~rst_i & ~empty & core.rready;

    sp_ram_rsp_fifo #(
        .DEPTH   (RSP_DEPTH),
        .entry_t (entry_t)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst_i),
        .push      (push),
        .push_data (captured),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .empty     (empty)
    );

    // Response output: head of buffer if occupied, else the pass-through entry
    always_comb begin
        rsp_out = empty ? captured : head;
        rvalid  = ~rst_i & (inflight_valid | ~empty);
    end

    assign core.rvalid = rvalid;
    assign core.rdata  = rvalid ? rsp_out.data : '0;
    assign core.rtag   = rvalid ? rsp_out.tag  : '0;

endmodule

// File: tb/tb_sp_ram_initiator.sv
// tb/tb_sp_ram_initiator.sv - directed self-checking bench for sp_ram_initiator
module tb_sp_ram_initiator;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_en;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [31:0] ram_wdata;
    logic        ram_we_tag;
    logic        ram_wdata_tag;
    logic [31:0] ram_rdata;
    logic [3:0]  ram_rdata_tag;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] mem  [8192];
    logic [3:0]  tmem [8192];

    always #5 clk = ~clk;

    sp_ram_initiator_if #(.ADDR_WIDTH(15), .DATA_WIDTH(32)) bus ();

    sp_ram_initiator #(
        .ADDR_WIDTH (15),
        .DATA_WIDTH (32),
        .RSP_DEPTH  (2)
    ) dut (
        .clk             (clk),
        .rst_i           (rst),
        .core            (bus),
        .ram_en_o        (ram_en),
        .ram_addr_o      (ram_addr),
        .ram_we_o        (ram_we),
        .ram_be_o        (ram_be),
        .ram_wdata_o     (ram_wdata),
        .ram_we_tag_o    (ram_we_tag),
        .ram_wdata_tag_o (ram_wdata_tag),
        .ram_rdata_i     (ram_rdata),
        .ram_rdata_tag_i (ram_rdata_tag)
    );

    // Behavioural RAM: byte writes, per-byte tags, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we || ram_we_tag) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) begin
                        if (ram_we) mem[ram_addr[14:2]][b*8 +: 8] = ram_wdata[b*8 +: 8];
                        if (ram_we_tag) tmem[ram_addr[14:2]][b] = ram_wdata_tag;
                    end
                end
            end else begin
                ram_rdata     <= mem[ram_addr[14:2]];
                ram_rdata_tag <= tmem[ram_addr[14:2]];
            end
        end
    end

    task automatic drive_idle();
        bus.req = 1'b0; bus.addr = '0; bus.we = 1'b0; bus.tag_only = 1'b0;
        bus.be = '0; bus.wdata = '0; bus.wtag = 1'b0;
    endtask

    task automatic drive_load(input logic [14:0] a);
        bus.req = 1'b1; bus.addr = a; bus.we = 1'b0; bus.tag_only = 1'b0;
        bus.be = 4'hF; bus.wdata = '0; bus.wtag = 1'b0;
    endtask

    task automatic drive_store(input logic [14:0] a, input logic [3:0] be, input logic [31:0] d,
                               input logic t, input logic tonly);
        bus.req = 1'b1; bus.addr = a; bus.we = 1'b1; bus.tag_only = tonly;
        bus.be = be; bus.wdata = d; bus.wtag = t;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.rready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); drive_load(15'h0010); #1;
            vectors++; if (bus.gnt !== 1'b0) begin miscompares++; $display("FAIL reset_gnt: got %b want 0", bus.gnt); end
            vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL reset_ram_en: got %b want 0", ram_en); end
            vectors++; if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid: got %b want 0", bus.rvalid); end
            vectors++; if (bus.rdata !== 32'h0 || bus.rtag !== 4'h0) begin miscompares++; $display("FAIL reset_rdata: got %h/%h want 0/0", bus.rdata, bus.rtag); end
        end
        @(negedge clk); rst = 1'b0; drive_idle(); #1;
        vectors++; if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL post_reset_rvalid: got %b want 0", bus.rvalid); end
    endtask

    task automatic test_store_load();
        bus.rready = 1'b1;
        @(negedge clk); drive_store(15'h0010, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0); #1;
        vectors++; if (bus.gnt !== 1'b1) begin miscompares++; $display("FAIL st_gnt: got %b want 1", bus.gnt); end
        vectors++; if ({ram_en, ram_we, ram_we_tag, ram_wdata_tag} !== 4'b1111) begin miscompares++; $display("FAIL st_ctrl: got %b want 1111", {ram_en, ram_we, ram_we_tag, ram_wdata_tag}); end
        vectors++; if (ram_be !== 4'hF || ram_wdata !== 32'hDEADBEEF || ram_addr !== 15'h0010) begin miscompares++; $display("FAIL st_bus: got be=%h wd=%h a=%h want f/deadbeef/0010", ram_be, ram_wdata, ram_addr); end
        @(negedge clk); drive_load(15'h0010); #1;
        vectors++; if ({bus.gnt, ram_en, ram_we, ram_we_tag} !== 4'b1100) begin miscompares++; $display("FAIL ld_ctrl: got %b want 1100", {bus.gnt, ram_en, ram_we, ram_we_tag}); end
        vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0 || bus.rtag !== 4'h0) begin miscompares++; $display("FAIL st_rsp: got v=%b d=%h t=%h want 1/0/0", bus.rvalid, bus.rdata, bus.rtag); end
        @(negedge clk); drive_idle(); #1;
        vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEADBEEF || bus.rtag !== 4'hF) begin miscompares++; $display("FAIL ld_rsp: got v=%b d=%h t=%h want 1/deadbeef/f", bus.rvalid, bus.rdata, bus.rtag); end
        vectors++; if (ram_en !== 1'b0) begin miscompares++; $display("FAIL idle_ram_en: got %b want 0", ram_en); end
        @(negedge clk); #1;
        vectors++; if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL ld_done: got %b want 0", bus.rvalid); end
    endtask

    task automatic test_tag_only();
        bus.rready = 1'b1;
        @(negedge clk); drive_store(15'h0010, 4'b0011, 32'h12345678, 1'b0, 1'b1); #1;
        vectors++; if ({bus.gnt, ram_we, ram_we_tag, ram_wdata_tag} !== 4'b1010) begin miscompares++; $display("FAIL tag_st_ctrl: got %b want 1010", {bus.gnt, ram_we, ram_we_tag, ram_wdata_tag}); end
        vectors++; if (ram_be !== 4'b0011) begin miscompares++; $display("FAIL tag_st_be: got %b want 0011", ram_be); end
        @(negedge clk); drive_load(15'h0010); #1;
        vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h0) begin miscompares++; $display("FAIL tag_st_rsp: got v=%b d=%h want 1/0", bus.rvalid, bus.rdata); end
        @(negedge clk); drive_idle(); #1;
        vectors++; if (bus.rdata !== 32'hDEADBEEF || bus.rtag !== 4'b1100) begin miscompares++; $display("FAIL tag_ld_rsp: got d=%h t=%b want deadbeef/1100", bus.rdata, bus.rtag); end
        @(negedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [14:0] la [4];
        logic [31:0] ld [4];
        logic [3:0]  lt [4];
        logic [8:0]  exp_gnt;
        logic [8:0]  exp_rv;
        int          exp_idx [9];
        int          k;
        la[0] = 15'h0010; ld[0] = 32'hDEADBEEF; lt[0] = 4'b1100;
        la[1] = 15'h0020; ld[1] = 32'h11112222; lt[1] = 4'b1111;
        la[2] = 15'h0024; ld[2] = 32'h33334444; lt[2] = 4'b0000;
        la[3] = 15'h0010; ld[3] = 32'hDEADBEEF; lt[3] = 4'b1100;
        exp_gnt = 9'b001100011;
        exp_rv  = 9'b011111110;
        exp_idx = '{-1, 0, 0, 0, 0, 1, 2, 3, -1};
        bus.rready = 1'b1;
        @(negedge clk); drive_store(15'h0020, 4'hF, 32'h11112222, 1'b1, 1'b0);
        @(negedge clk); drive_store(15'h0024, 4'hF, 32'h33334444, 1'b0, 1'b0);
        @(negedge clk); drive_idle();
        @(negedge clk);
        k = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            bus.rready = (c >= 4);
            if (k < 4) drive_load(la[k]); else drive_idle();
            #1;
            vectors++; if (bus.gnt !== exp_gnt[c]) begin miscompares++; $display("FAIL bp_gnt[%0d]: got %b want %b", c, bus.gnt, exp_gnt[c]); end
            vectors++; if (bus.rvalid !== exp_rv[c]) begin miscompares++; $display("FAIL bp_rvalid[%0d]: got %b want %b", c, bus.rvalid, exp_rv[c]); end
            if (exp_idx[c] >= 0) begin
                vectors++;
                if (bus.rdata !== ld[exp_idx[c]] || bus.rtag !== lt[exp_idx[c]]) begin
                    miscompares++;
                    $display("FAIL bp_data[%0d]: got %h/%b want %h/%b", c, bus.rdata, bus.rtag, ld[exp_idx[c]], lt[exp_idx[c]]);
                end
            end
            if (bus.gnt === 1'b1) k++;
        end
    endtask

    task automatic test_streaming();
        logic [31:0] ld [2];
        int k;
        ld[0] = 32'h11112222; ld[1] = 32'h33334444;
        bus.rready = 1'b1;
        k = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            if (k < 8) drive_load((k % 2 == 0) ? 15'h0020 : 15'h0024); else drive_idle();
            #1;
            vectors++; if (bus.gnt !== (c < 8)) begin miscompares++; $display("FAIL stream_gnt[%0d]: got %b want %b", c, bus.gnt, (c < 8)); end
            vectors++; if (bus.rvalid !== (c >= 1)) begin miscompares++; $display("FAIL stream_rvalid[%0d]: got %b want %b", c, bus.rvalid, (c >= 1)); end
            if (c >= 1) begin
                vectors++;
                if (bus.rdata !== ld[(c - 1) % 2]) begin miscompares++; $display("FAIL stream_data[%0d]: got %h want %h", c, bus.rdata, ld[(c - 1) % 2]); end
            end
            if (bus.gnt === 1'b1) k++;
        end
        @(negedge clk); #1;
        vectors++; if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL stream_end: got %b want 0", bus.rvalid); end
    endtask

    task automatic test_reset_mid();
        bus.rready = 1'b0;
        @(negedge clk); drive_load(15'h0020);
        @(negedge clk); drive_load(15'h0024);
        @(negedge clk); rst = 1'b1; drive_load(15'h0010); #1;
        vectors++; if ({bus.gnt, ram_en, bus.rvalid} !== 3'b000) begin miscompares++; $display("FAIL rst_mid: got gnt/en/rv=%b want 000", {bus.gnt, ram_en, bus.rvalid}); end
        @(negedge clk); rst = 1'b0; drive_idle(); #1;
        vectors++; if ({ram_en, bus.rvalid} !== 2'b00) begin miscompares++; $display("FAIL rst_flush: got en/rv=%b want 00", {ram_en, bus.rvalid}); end
        @(negedge clk); bus.rready = 1'b1; drive_load(15'h0010); #1;
        vectors++; if ({bus.gnt, bus.rvalid} !== 2'b10) begin miscompares++; $display("FAIL rst_reload: got gnt/rv=%b want 10", {bus.gnt, bus.rvalid}); end
        @(negedge clk); drive_idle(); #1;
        vectors++; if (bus.rvalid !== 1'b1 || bus.rdata !== 32'hDEADBEEF || bus.rtag !== 4'b1100) begin miscompares++; $display("FAIL rst_reload_rsp: got v=%b d=%h t=%b want 1/deadbeef/1100", bus.rvalid, bus.rdata, bus.rtag); end
        @(negedge clk); #1;
        vectors++; if (bus.rvalid !== 1'b0) begin miscompares++; $display("FAIL rst_no_replay: got %b want 0", bus.rvalid); end
    endtask

    initial begin
        rst = 1'b1;
        bus.rready = 1'b1;
        drive_idle();
        test_reset();
        test_store_load();
        test_tag_only();
        test_backpressure();
        test_streaming();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
